// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX pin between the SoC UART and a sysmon monitor, switching only at idle gaps.
// Optional SoC drop counter is built when UART_ARB_DROP_CNT_EN is defined.
module uart_tx_arbiter #(
  parameter int CLK_FREQ        = 20000000,
  parameter int BAUD_RATE       = 115200,
  parameter int GUARD_BITS      = 2,
  parameter int MAX_HOLD_CYCLES = CLK_FREQ / 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soc_tx,
  input  logic       mon_tx,
  input  logic       mon_req,
  output logic       tx_out,
  output logic       mon_grant,
  output logic       arb_timeout,
  output logic [7:0] soc_drop_cnt
);

  localparam int BIT_CYC   = CLK_FREQ / BAUD_RATE;
  localparam int GUARD_CYC = GUARD_BITS * BIT_CYC;
  localparam int GW        = $clog2(GUARD_CYC + 1);
  localparam int HW        = $clog2(MAX_HOLD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(MAX_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {SOC_OWN, DRAIN_SOC, MON_OWN, DRAIN_MON} state_t;

  state_t        state, next_state;
  logic [GW-1:0] guard_cnt, guard_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          rearm, rearm_nxt;
  logic          tx_nxt, grant_nxt, timeout_nxt;
  logic          watched;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SOC_OWN;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SOC_OWN:   if (mon_req && rearm) next_state = DRAIN_SOC;
      DRAIN_SOC: begin
        if (!mon_req)                             next_state = SOC_OWN;
        else if (soc_tx && guard_cnt == GUARD_LAST) next_state = MON_OWN;
      end
      MON_OWN:   if (!mon_req || hold_cnt == HOLD_LAST) next_state = DRAIN_MON;
      DRAIN_MON: if (mon_tx && guard_cnt == GUARD_LAST) next_state = SOC_OWN;
      default:   next_state = SOC_OWN;
    endcase
  end

  always_comb begin
    watched     = (state == DRAIN_MON) ? mon_tx : soc_tx;
    tx_nxt      = (state == SOC_OWN || state == DRAIN_SOC) ? soc_tx : mon_tx;
    grant_nxt   = (next_state == MON_OWN);
    // A release requested on the timeout cycle itself is a normal release.
    timeout_nxt = (state == MON_OWN) && mon_req && (hold_cnt == HOLD_LAST);
    rearm_nxt   = rearm;
    if (!mon_req)         rearm_nxt = 1'b1;
    else if (timeout_nxt) rearm_nxt = 1'b0;
    guard_nxt = '0;
    if ((state == DRAIN_SOC || state == DRAIN_MON) && next_state == state && watched)
      guard_nxt = guard_cnt + 1'b1;
    hold_nxt = '0;
    if (state == MON_OWN && next_state == MON_OWN)
      hold_nxt = hold_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_cnt   <= '0;
      hold_cnt    <= '0;
      rearm       <= 1'b1;
      tx_out      <= 1'b1;
      mon_grant   <= 1'b0;
      arb_timeout <= 1'b0;
    end else begin
      guard_cnt   <= guard_nxt;
      hold_cnt    <= hold_nxt;
      rearm       <= rearm_nxt;
      tx_out      <= tx_nxt;
      mon_grant   <= grant_nxt;
      arb_timeout <= timeout_nxt;
    end
  end

`ifdef UART_ARB_DROP_CNT_EN
  logic       soc_prev;
  logic [7:0] drop_cnt;

  // SoC start bits seen while the monitor holds the pin are lost; count them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soc_prev <= 1'b1;
      drop_cnt <= 8'd0;
    end else begin
      soc_prev <= soc_tx;
      if ((state == MON_OWN || state == DRAIN_MON) && soc_prev && !soc_tx && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign soc_drop_cnt = drop_cnt;
`else
  assign soc_drop_cnt = 8'd0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLK_FREQ, default 20000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line baud rate; BIT_CYC = CLK_FREQ/BAUD_RATE (integer division).
REQ-003 Parameter GUARD_BITS, default 2, idle guard length in bit periods; GUARD_CYC = GUARD_BITS*BIT_CYC.
REQ-004 Parameter MAX_HOLD_CYCLES, default CLK_FREQ/10, maximum monitor ownership in cycles.
REQ-005 clk  input  1  single system clock, all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 soc_tx  input  1  serial TX line from the SoC UART, idle high.
REQ-008 mon_tx  input  1  serial TX line from the sysmon monitor, idle high.
REQ-009 mon_req  input  1  level request from the monitor, held high for a whole packet.
REQ-010 tx_out  output  1  registered shared pin line.
REQ-011 mon_grant  output  1  high while the monitor owns the line.
REQ-012 arb_timeout  output  1  one-cycle pulse on forced monitor release.
REQ-013 soc_drop_cnt  output  8  count of SoC start bits lost while the monitor owned the line.

Function
REQ-014 The FSM SHALL have states SOC_OWN, DRAIN_SOC, MON_OWN and DRAIN_MON.
REQ-015 tx_out SHALL equal the owner line sampled on the previous cycle (1-cycle latency): soc_tx in SOC_OWN/DRAIN_SOC, mon_tx in MON_OWN/DRAIN_MON.
REQ-016 Guard counter: increments while the watched line is 1, clears on any 0 sample, clears on every state entry.
REQ-017 SOC_OWN -> DRAIN_SOC when mon_req=1 and rearm=1; watched line is soc_tx.
REQ-018 DRAIN_SOC -> SOC_OWN if mon_req=0; -> MON_OWN when the guard count reaches GUARD_CYC-1 with soc_tx=1.
REQ-019 mon_grant SHALL be 1 exactly in MON_OWN; it rises on the cycle after MON_OWN entry and is registered.
REQ-020 MON_OWN: hold counter increments each cycle from 0 at entry; mon_req=0 -> DRAIN_MON.
REQ-021 MON_OWN: hold counter reaching MAX_HOLD_CYCLES-1 with mon_req=1 -> DRAIN_MON, arb_timeout pulses 1 cycle, rearm cleared.
REQ-022 If mon_req=0 and the timeout hit the same cycle, the block SHALL take the normal release: no pulse, rearm unchanged.
REQ-023 DRAIN_MON -> SOC_OWN when the guard count on mon_tx reaches GUARD_CYC-1 with mon_tx=1; mon_req is ignored in DRAIN_MON.
REQ-024 rearm SHALL set on any cycle with mon_req=0, so a timed-out monitor is not re-granted until it drops its request.
REQ-025 A soc_tx falling edge (previous sample 1, current 0) in MON_OWN or DRAIN_MON SHALL increment soc_drop_cnt, saturating at 255.
REQ-026 A SoC start bit during DRAIN_SOC SHALL restart the guard (REQ-016), never be dropped, and pass to tx_out.

Reset
REQ-027 On rst_n=0, asynchronously: state=SOC_OWN, tx_out=1, mon_grant=0, arb_timeout=0, soc_drop_cnt=0, rearm=1, all counters 0, edge-detect history=1.
REQ-028 Reset mid-packet SHALL abandon the packet, with tx_out at 1 and the SoC owning the line from the first cycle after release.

Configuration
REQ-029 Macro UART_ARB_DROP_CNT_EN defined: soc_drop_cnt logic per REQ-025.
REQ-030 Macro UART_ARB_DROP_CNT_EN undefined: soc_drop_cnt tied to 0, no edge detector or counter registers synthesised, all other behaviour identical.

Verification (CLK_FREQ=1000, BAUD_RATE=100, GUARD_BITS=2 -> GUARD_CYC=20, MAX_HOLD_CYCLES=500)
REQ-031 soc_tx idle, mon_req rises at cycle 0 -> mon_grant=1 at cycle 21; tx_out follows mon_tx with 1-cycle lag.
REQ-032 mon_req rises, soc_tx pulses low at cycle 10 -> grant is delayed until 20 consecutive high cycles after the pulse; the pulse appears on tx_out; soc_drop_cnt=0.
REQ-033 While granted, 3 SoC start bits sent -> soc_drop_cnt=3 and tx_out never shows soc_tx; with the macro undefined -> soc_drop_cnt=0.
REQ-034 mon_req held for 600 cycles -> arb_timeout pulses 500 cycles after grant and mon_grant falls; no re-grant until mon_req goes 0 then 1.
REQ-035 mon_req drops with mon_tx low mid-byte -> line stays with the monitor until mon_tx is high for 20 cycles, then returns to SOC_OWN.
REQ-036 rst_n asserted during MON_OWN -> tx_out=1, mon_grant=0 immediately; after release, a new mon_req is granted 21 cycles later with soc_tx idle.
